// File: rtl/wb_sdrc_bridge.sv
// rtl/wb_sdrc_bridge.sv - Wishbone classic slave to SDRAM controller application-port bridge
module wb_sdrc_bridge #(
    parameter int dw      = 32,
    parameter int APP_AW  = 26,
    parameter int TIMEOUT = 255
) (
    input  logic              sys_clk,
    input  logic              resetn,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [APP_AW-1:0] wb_addr_i,
    input  logic [dw-1:0]     wb_dat_i,
    input  logic [dw/8-1:0]   wb_sel_i,
    output logic [dw-1:0]     wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic              app_req,
    output logic [APP_AW-1:0] app_req_addr,
    output logic [8:0]        app_req_len,
    output logic              app_req_wr_n,
    input  logic              app_req_ack,
    output logic [dw-1:0]     app_wr_data,
    output logic [dw/8-1:0]   app_wr_en_n,
    input  logic              app_wr_next_req,
    input  logic [dw-1:0]     app_rd_data,
    input  logic              app_rd_valid
);
    localparam int SW = dw / 8;
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WDATA, S_RDATA, S_ACK} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_cnt;
    logic              r_abort;
    logic              r_we;
    logic [APP_AW-1:0] r_addr;
    logic [dw-1:0]     r_dat;
    logic [SW-1:0]     r_sel;
    logic              r_app_req;
    logic              r_wr_n;
    logic [SW-1:0]     r_en_n;
    logic              r_ack;
    logic              r_err;
    logic [dw-1:0]     r_rdat;

    logic              w_start;
    logic              w_hs;
    logic              w_expire;
    logic              w_aborted;
    logic              w_app_req;
    logic              w_wr_n;
    logic [SW-1:0]     w_en_n;
    logic              w_ack;
    logic              w_err;
    logic [dw-1:0]     w_rdat;

    // A new cycle is only taken once the previous ack/err pulse has been seen
    assign w_start   = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err;
    // Expiry is when the last permitted waiting cycle passes without a handshake
    assign w_expire  = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));
    // Master walked away either earlier in this transaction or right now
    assign w_aborted = r_abort | ~wb_cyc_i;

    assign wb_dat_o     = r_rdat;
    assign wb_ack_o     = r_ack;
    assign wb_err_o     = r_err;
    assign app_req      = r_app_req;
    assign app_req_addr = r_addr;
    assign app_req_len  = 9'd1;
    assign app_req_wr_n = r_wr_n;
    assign app_wr_data  = r_dat;
    assign app_wr_en_n  = r_en_n;

    // Select the handshake the current state is waiting on
    always_comb begin
        w_hs = 1'b0;
        case (r_state)
            S_REQ:   w_hs = r_app_req & app_req_ack;
            S_WDATA: w_hs = app_wr_next_req;
            S_RDATA: w_hs = app_rd_valid;
            default: w_hs = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next-state logic; a handshake arriving on the expiry cycle takes priority
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_REQ;
            S_REQ:   if (w_hs) w_next = r_we ? S_WDATA : S_RDATA;
                     else if (w_expire) w_next = S_IDLE;
            S_WDATA: if (w_hs) w_next = S_ACK;
                     else if (w_expire) w_next = S_IDLE;
            S_RDATA: if (w_hs) w_next = S_ACK;
                     else if (w_expire) w_next = S_IDLE;
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        w_app_req = r_app_req;
        w_wr_n    = r_wr_n;
        w_en_n    = r_en_n;
        w_rdat    = r_rdat;
        w_ack     = 1'b0;
        w_err     = 1'b0;
        case (r_state)
            S_REQ: begin
                w_wr_n = ~r_we;
                if (w_hs) begin
                    w_app_req = 1'b0;
                    if (r_we) w_en_n = ~r_sel;
                end else if (w_expire) begin
                    w_app_req = 1'b0;
                    w_err     = ~w_aborted;
                end else begin
                    w_app_req = 1'b1;
                end
            end
            S_WDATA: begin
                if (w_hs || w_expire) w_en_n = '1;
                if (!w_hs && w_expire) w_err = ~w_aborted;
            end
            S_RDATA: begin
                if (w_hs) w_rdat = app_rd_data;
                else if (w_expire) w_err = ~w_aborted;
            end
            S_ACK:   w_ack = ~w_aborted;
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn) begin
            r_app_req <= 1'b0;
            r_wr_n    <= 1'b1;
            r_en_n    <= '1;
            r_rdat    <= '0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_app_req <= w_app_req;
            r_wr_n    <= w_wr_n;
            r_en_n    <= w_en_n;
            r_rdat    <= w_rdat;
            r_ack     <= w_ack;
            r_err     <= w_err;
        end
    end

    // Capture the Wishbone request when it is accepted
    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn) begin
            r_addr <= '0;
            r_dat  <= '0;
            r_sel  <= '0;
            r_we   <= 1'b0;
        end else if (r_state == S_IDLE && w_start) begin
            r_addr <= wb_addr_i;
            r_dat  <= wb_dat_i;
            r_sel  <= wb_sel_i;
            r_we   <= wb_we_i;
        end
    end

    // Timeout counter: cleared on acceptance, counts while waiting on the controller
    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_start) r_cnt <= '0;
        end else if (r_state != S_ACK) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Abort flag: sticky while a transaction is outstanding, cleared back in IDLE
    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn)                                   r_abort <= 1'b0;
        else if (r_state == S_IDLE || w_next == S_IDLE) r_abort <= 1'b0;
        else                                           r_abort <= w_aborted;
    end
endmodule

// File: tb/tb_wb_sdrc_bridge.sv
// tb/tb_wb_sdrc_bridge.sv - scoreboard testbench for wb_sdrc_bridge
module tb_wb_sdrc_bridge;
    localparam int DW = 32;
    localparam int AW = 26;
    localparam int TO = 8;

    logic          sys_clk = 1'b0;
    logic          resetn;
    logic          wb_cyc_i, wb_stb_i, wb_we_i;
    logic [AW-1:0] wb_addr_i;
    logic [DW-1:0] wb_dat_i;
    logic [3:0]    wb_sel_i;
    logic [DW-1:0] wb_dat_o;
    logic          wb_ack_o, wb_err_o;
    logic          app_req;
    logic [AW-1:0] app_req_addr;
    logic [8:0]    app_req_len;
    logic          app_req_wr_n;
    logic          app_req_ack;
    logic [DW-1:0] app_wr_data;
    logic [3:0]    app_wr_en_n;
    logic          app_wr_next_req;
    logic [DW-1:0] app_rd_data;
    logic          app_rd_valid;

    wb_sdrc_bridge #(.dw(DW), .APP_AW(AW), .TIMEOUT(TO)) dut (
        .sys_clk(sys_clk), .resetn(resetn),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_addr_i(wb_addr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .app_req(app_req), .app_req_addr(app_req_addr), .app_req_len(app_req_len),
        .app_req_wr_n(app_req_wr_n), .app_req_ack(app_req_ack),
        .app_wr_data(app_wr_data), .app_wr_en_n(app_wr_en_n),
        .app_wr_next_req(app_wr_next_req),
        .app_rd_data(app_rd_data), .app_rd_valid(app_rd_valid)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        bit          is_err;
        bit          chk_data;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   got_resp;
    bit   prev_resp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every ack/err presented by the DUT is matched against the scoreboard
    always @(negedge sys_clk) begin
        if (resetn && (wb_ack_o || wb_err_o)) begin
            chk("resp_single_pulse", {31'b0, prev_resp}, 32'd0);
            if (q.size() == 0) begin
                chk("unexpected_resp", {30'b0, wb_ack_o, wb_err_o}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("resp_kind", {30'b0, wb_ack_o, wb_err_o}, e.is_err ? 32'd1 : 32'd2);
                if (e.chk_data) chk("read_data", wb_dat_o, e.data);
            end
        end
        prev_resp = resetn && (wb_ack_o || wb_err_o);
    end

    // One negedge; the master ends its cycle as soon as it sees ack or err
    task automatic step();
        @(negedge sys_clk);
        if (wb_ack_o || wb_err_o) begin
            wb_cyc_i = 1'b0;
            wb_stb_i = 1'b0;
            got_resp = 1'b1;
        end
    endtask

    task automatic issue(input bit we, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        step();
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_addr_i = a; wb_dat_i = d; wb_sel_i = s;
        got_resp = 1'b0;
    endtask

    task automatic wait_req(input logic [AW-1:0] a, input bit wr_n);
        int n = 0;
        while (!app_req && n < 20) begin step(); n++; end
        chk("req_seen", {31'b0, app_req}, 32'd1);
        chk("req_addr", {6'b0, app_req_addr}, {6'b0, a});
        chk("req_wr_n", {31'b0, app_req_wr_n}, {31'b0, wr_n});
        chk("req_len", {23'b0, app_req_len}, 32'd1);
    endtask

    task automatic wait_resp();
        int n = 0;
        while (!got_resp && n < 30) begin step(); n++; end
        chk("resp_arrived", {31'b0, got_resp}, 32'd1);
    endtask

    task automatic write_txn(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s, input int nr_dly);
        q.push_back('{is_err: 1'b0, chk_data: 1'b0, data: 32'h0});
        issue(1'b1, a, d, s);
        wait_req(a, 1'b0);
        app_req_ack = 1'b1;
        step();
        app_req_ack = 1'b0;
        chk("req_dropped", {31'b0, app_req}, 32'd0);
        chk("wdata_en_n", {28'b0, app_wr_en_n}, {28'b0, ~s});
        chk("wdata_data", app_wr_data, d);
        repeat (nr_dly - 1) step();
        app_wr_next_req = 1'b1;
        step();
        app_wr_next_req = 1'b0;
        chk("en_n_released", {28'b0, app_wr_en_n}, 32'hF);
        wait_resp();
    endtask

    task automatic read_txn(input logic [AW-1:0] a, input logic [31:0] d, input int v_dly, input bit exp_err);
        q.push_back('{is_err: exp_err, chk_data: !exp_err, data: d});
        issue(1'b0, a, 32'h0, 4'hF);
        wait_req(a, 1'b1);
        app_req_ack = 1'b1;
        step();
        app_req_ack = 1'b0;
        repeat (v_dly - 1) step();
        app_rd_valid = 1'b1; app_rd_data = d;
        step();
        app_rd_valid = 1'b0; app_rd_data = 32'h0;
        wait_resp();
    endtask

    initial begin
        resetn = 1'b0;
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_addr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
        app_req_ack = 0; app_wr_next_req = 0; app_rd_data = '0; app_rd_valid = 0;
        got_resp = 0; prev_resp = 0;
        repeat (3) @(negedge sys_clk);
        chk("rst_app_req", {31'b0, app_req}, 32'd0);
        chk("rst_wr_n", {31'b0, app_req_wr_n}, 32'd1);
        chk("rst_en_n", {28'b0, app_wr_en_n}, 32'hF);
        chk("rst_ack_err", {30'b0, wb_ack_o, wb_err_o}, 32'd0);
        chk("rst_dat_o", wb_dat_o, 32'h0);
        resetn = 1'b1;
        step();

        write_txn(26'h123, 32'hDEADBEEF, 4'b1111, 1);
        read_txn(26'h3FFFFFF, 32'hA5A50F0F, 5, 1'b0);
        write_txn(26'h55, 32'h11223344, 4'b0101, 2);
        read_txn(26'h10, 32'h0BADF00D, 1, 1'b0);
        // rd_valid lands on the very cycle the timer expires: data wins
        read_txn(26'h20, 32'h600DCAFE, 6, 1'b0);
        // rd_valid one cycle too late: timeout error, read data register untouched
        read_txn(26'h21, 32'h12345678, 7, 1'b1);
        chk("dat_o_held", wb_dat_o, 32'h600DCAFE);

        // Controller never accepts: app_req must drop 8 cycles after acceptance with err
        begin
            int  n = 0;
            bit  hi = 0;
            q.push_back('{is_err: 1'b1, chk_data: 1'b0, data: 32'h0});
            issue(1'b0, 26'h44, 32'h0, 4'hF);
            while (n < 40) begin
                step(); n++;
                if (app_req) hi = 1;
                if (hi && !app_req) break;
            end
            chk("timeout_cycles", n - 1, TO);
            chk("timeout_err", {31'b0, wb_err_o}, 32'd1);
            wait_resp();
        end

        // Master abandons the cycle during RDATA: app side completes, no ack
        issue(1'b0, 26'h66, 32'h0, 4'hF);
        wait_req(26'h66, 1'b1);
        app_req_ack = 1'b1;
        step();
        app_req_ack = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        step();
        app_rd_valid = 1'b1; app_rd_data = 32'hFFFF0000;
        step();
        app_rd_valid = 1'b0;
        repeat (5) step();
        chk("abort_no_resp", {31'b0, got_resp}, 32'd0);
        write_txn(26'h67, 32'h5A5A5A5A, 4'b1001, 1);

        // Reset pulsed while in WDATA
        issue(1'b1, 26'h77, 32'hCAFEF00D, 4'b0011);
        wait_req(26'h77, 1'b0);
        app_req_ack = 1'b1;
        step();
        app_req_ack = 1'b0;
        chk("pre_rst_en_n", {28'b0, app_wr_en_n}, 32'hC);
        resetn = 1'b0;
        #1;
        chk("rst_mid_app_req", {31'b0, app_req}, 32'd0);
        chk("rst_mid_en_n", {28'b0, app_wr_en_n}, 32'hF);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        step();
        resetn = 1'b1;
        repeat (12) step();
        chk("rst_no_resp", {31'b0, got_resp}, 32'd0);
        read_txn(26'h3, 32'h01020304, 2, 1'b0);

        repeat (3) step();
        chk("scoreboard_empty", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
